mem_port_sched: RTL and testbench
=================================

# mem_port_sched

Two-requester scheduler for the single byte-serial main-memory port. It lets two block-level requesters, the instruction-side and data-side cache line fill/writeback engines, share one memory controller. Each grant runs one whole 4-byte line transaction. The block serialises a 32-bit write block into byte beats, deserialises read beats into a 32-bit block, and arbitrates round-robin between the two requesters.

## Interface
Parameters:
- AWIDTH, 16, address width
- DWIDTH, 8, memory beat width
- BLOCKSIZE, 4, beats per line; line width LW = DWIDTH*BLOCKSIZE

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req / m1_req  in  1  level request; held until matching done pulse
- m0_we / m1_we  in  1  1 = line write, 0 = line read; sampled at grant
- m0_addr / m1_addr  in  AWIDTH  byte address; [1:0] ignored; sampled at grant
- m0_wdata / m1_wdata  in  LW  write line, byte 0 in [7:0]; sampled at grant
- m0_gnt / m1_gnt  out  1  one-cycle pulse: request accepted
- m0_done / m1_done  out  1  one-cycle pulse: transaction complete
- m0_rdata / m1_rdata  out  LW  read line; valid from done, held until that port's next read completes
- addr_mem  out  AWIDTH  {addr[AWIDTH-1:2],2'b00}
- rd_mem  out  1  read command
- wr_mem  out  1  write command
- wdata_mem  out  DWIDTH  write beat
- rdata_mem  in  DWIDTH  read beat
- ready_mem  in  1  memory idle/ready

## Operation
- States: IDLE, WAIT, RBURST, DONE.
- IDLE:
  - Start only if (m0_req|m1_req) & ready_mem.
  - Pick the winner: a lone requester wins; if both request, the port at the priority pointer wins.
  - Latch addr, we and wdata; pulse gnt_x.
  - Drive rd_mem or wr_mem = 1 and addr_mem; set wdata_mem = wdata[7:0] and beat = 0.
  - Go to WAIT.
  - With ready_mem = 0, stay in IDLE and issue nothing.
- WAIT:
  - rd_mem/wr_mem held high until the first cycle ready_mem = 0 is sampled, then deasserted.
  - Write: the memory samples wdata_mem in each cycle with ready_mem = 0. The scheduler then advances wdata_mem to the next byte, LSB first. After BLOCKSIZE beats it drives wdata_mem = 0; extra low cycles are ignored.
  - On ready_mem = 1 after the low phase: a write goes to DONE, a read goes to RBURST.
  - If ready_mem never drops, WAIT holds indefinitely (no timeout).
- RBURST:
  - Samples rdata_mem on BLOCKSIZE consecutive cycles, starting with the first RBURST cycle.
  - Assembly is LSB first: beat 0 → [7:0].
  - ready_mem is ignored here.
  - After the last beat go to DONE.
- DONE:
  - Pulse done_x for the granted port.
  - For a read, update rdata_x.
  - Set the priority pointer to the other port, then go to IDLE.
- The requester must drop req the cycle after done. A req still high in the following IDLE is a new request.
- rd_mem and wr_mem are never high together. Only one transaction is outstanding at a time.
- Reset (any state, asynchronous): state = IDLE, priority pointer = port 0, transaction abandoned. All outputs go to 0: gnt, done, rdata, addr_mem, rd_mem, wr_mem, wdata_mem.

## Timing
- Grant decision is made in IDLE; gnt_x, rd_mem/wr_mem and addr_mem are registered and visible the next cycle.
- Read latency (grant edge to done): 1 + L + BLOCKSIZE + 1 cycles, where L = memory busy (ready low) cycles.
- Write latency: 1 + L + 1 cycles; L ≥ BLOCKSIZE is guaranteed by the memory.
- Minimum gap between transactions is one IDLE cycle.
- A priority pointer update takes effect for the next IDLE decision.
- Beat counter width is clog2(BLOCKSIZE)+1 and saturates at BLOCKSIZE.

## Structure
- Shared package mem_sched_pkg: state encodings, BLOCKSIZE/LW constants, port index constants (PORT0 = 0, PORT1 = 1).
- One sub-module, rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], pointer.
  - Outputs: one-hot grant.
  - Pointer update on an explicit advance strobe.
- Serialiser/deserialiser stays in the top module: a shift register plus beat counter.

## Test plan
- Single read: m0 reads addr 0x1234. Memory holds ready low 3 cycles, then returns 0x11,0x22,0x33,0x44. Expect addr_mem = 0x1234, rd_mem for 1 cycle, m0_rdata = 0x44332211, m0_done 9 cycles after gnt.
- Single write: m1 writes 0xDEADBEEF to 0x0040. Memory holds ready low 4 cycles. Expect wdata_mem beats EF,BE,AD,DE; wr_mem only; m1_done once; m1_rdata unchanged.
- Contention: m0 and m1 request in the same cycle after reset. Expect m0 granted first, m1 granted in the IDLE after m0_done. Repeated simultaneous requests alternate 1,0,1.
- ready_mem low in IDLE with m0_req high: no gnt, rd_mem and wr_mem stay 0 until ready_mem rises; grant follows next cycle.
- Reset asserted mid-RBURST after 2 beats: all outputs 0 immediately, no done. After release, a new m1 read completes normally with the priority pointer at port 0.
- Stuck memory: ready_mem never drops after rd_mem. Expect rd_mem held high indefinitely and no done; m1_req stays unserved.

Source files
------------

// File: rtl/mem_port_sched_pkg.sv
// Shared constants for the two-requester memory port scheduler:
// FSM state encodings, default line geometry and port indices.
package mem_sched_pkg;

   localparam int AWIDTH_DEF = 16;
   localparam int DWIDTH_DEF = 8;
   localparam int BLOCKSIZE  = 4;
   localparam int LW         = DWIDTH_DEF * BLOCKSIZE;

   typedef logic [1:0] sched_state_t;

   localparam sched_state_t ST_IDLE   = 2'd0;
   localparam sched_state_t ST_WAIT   = 2'd1;
   localparam sched_state_t ST_RBURST = 2'd2;
   localparam sched_state_t ST_DONE   = 2'd3;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_port_sched_if.sv
// Line-transaction handshake between one cache fill/writeback engine and the
// scheduler. master = requester side, slave = scheduler side.
interface mem_req_if #(
   parameter int AWIDTH = 16,
   parameter int LW     = mem_sched_pkg::LW
);
   logic              req;
   logic              we;
   logic [AWIDTH-1:0] addr;
   logic [LW-1:0]     wdata;
   logic              gnt;
   logic              done;
   logic [LW-1:0]     rdata;

   modport master (output req, we, addr, wdata, input gnt, done, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, done, rdata);

endinterface

// File: rtl/mem_port_sched_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the port that wins a tie and
// moves to the port opposite the one just served when advance is strobed.
module rr_arb2 import mem_sched_pkg::*; (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       served,
   output logic [1:0] grant
);

   logic pointer;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pointer <= PORT0;
      end else if (advance) begin
         pointer <= ~served;
      end
   end

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (pointer == PORT1) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_sched.sv
// Shares one byte-serial memory port between two line requesters; each grant
// moves one whole line, serialised/deserialised through a single shift register.
//
//   state  | meaning
//   IDLE   | wait for a request with memory ready, arbitrate, issue command
//   WAIT   | command out until memory goes busy; write beats leave on busy cycles
//   RBURST | collect BLOCKSIZE read beats, LSB first
//   DONE   | pulse done, publish read line, advance round-robin pointer
module mem_port_sched #(
   parameter int AWIDTH    = 16,
   parameter int DWIDTH    = 8,
   parameter int BLOCKSIZE = 4
) (
   input  logic              clock,
   input  logic              reset,
   mem_req_if.slave          m0,
   mem_req_if.slave          m1,
   output logic [AWIDTH-1:0] addr_mem,
   output logic              rd_mem,
   output logic              wr_mem,
   output logic [DWIDTH-1:0] wdata_mem,
   input  logic [DWIDTH-1:0] rdata_mem,
   input  logic              ready_mem
);
   import mem_sched_pkg::*;

   localparam int LINE_W = DWIDTH * BLOCKSIZE;
   localparam int BW     = $clog2(BLOCKSIZE) + 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(BLOCKSIZE - 1);
   localparam logic [BW-1:0] BEAT_FULL = BW'(BLOCKSIZE);

   sched_state_t        state;
   logic                cur;
   logic                we_q;
   logic                low_seen;
   logic [BW-1:0]       beat;
   logic [LINE_W-1:0]   shreg;
   logic [1:0]          gnt_q;
   logic [1:0]          done_q;
   logic [LINE_W-1:0]   rdata0_q;
   logic [LINE_W-1:0]   rdata1_q;

   logic [1:0]          req_v;
   logic [1:0]          arb_gnt;
   logic                arb_adv;
   logic                win;
   logic                we_sel;
   logic [AWIDTH-3:0]   addr_hi_sel;
   logic [LINE_W-1:0]   wdata_sel;
   logic                unused_addr_lsbs;

   assign req_v       = {m1.req, m0.req};
   assign arb_adv     = (state == ST_DONE);
   assign win         = arb_gnt[PORT1];
   assign we_sel      = win ? m1.we : m0.we;
   assign addr_hi_sel = win ? m1.addr[AWIDTH-1:2] : m0.addr[AWIDTH-1:2];
   assign wdata_sel   = win ? m1.wdata : m0.wdata;

   // Line-aligned addressing: the byte offset within a line is not used.
   assign unused_addr_lsbs = ^{m0.addr[1:0], m1.addr[1:0]};

   rr_arb2 u_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (req_v),
      .advance (arb_adv),
      .served  (cur),
      .grant   (arb_gnt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cur       <= PORT0;
         we_q      <= 1'b0;
         low_seen  <= 1'b0;
         beat      <= '0;
         shreg     <= '0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         addr_mem  <= '0;
         rd_mem    <= 1'b0;
         wr_mem    <= 1'b0;
         wdata_mem <= '0;
      end else begin
         gnt_q  <= 2'b00;
         done_q <= 2'b00;
         case (state)
            ST_IDLE: begin
               if ((|req_v) && ready_mem) begin
                  gnt_q     <= arb_gnt;
                  cur       <= win;
                  we_q      <= we_sel;
                  addr_mem  <= {addr_hi_sel, 2'b00};
                  rd_mem    <= ~we_sel;
                  wr_mem    <= we_sel;
                  shreg     <= wdata_sel;
                  wdata_mem <= wdata_sel[DWIDTH-1:0];
                  beat      <= '0;
                  low_seen  <= 1'b0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!ready_mem) begin
                  rd_mem   <= 1'b0;
                  wr_mem   <= 1'b0;
                  low_seen <= 1'b1;
                  // Memory took the current beat this cycle; present the next.
                  if (we_q && (beat != BEAT_FULL)) begin
                     beat      <= beat + 1'b1;
                     shreg     <= shreg >> DWIDTH;
                     wdata_mem <= (beat == BEAT_LAST) ? '0 : shreg[2*DWIDTH-1:DWIDTH];
                  end
               end else if (low_seen) begin
                  beat  <= '0;
                  state <= we_q ? ST_DONE : ST_RBURST;
               end
            end
            ST_RBURST: begin
               shreg <= {rdata_mem, shreg[LINE_W-1:DWIDTH]};
               beat  <= beat + 1'b1;
               if (beat == BEAT_LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q <= (cur == PORT1) ? 2'b10 : 2'b01;
               if (!we_q) begin
                  if (cur == PORT1) rdata1_q <= shreg;
                  else              rdata0_q <= shreg;
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign m0.gnt   = gnt_q[0];
   assign m1.gnt   = gnt_q[1];
   assign m0.done  = done_q[0];
   assign m1.done  = done_q[1];
   assign m0.rdata = rdata0_q;
   assign m1.rdata = rdata1_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: a behavioural byte-serial memory plus a line-level
// reference model (round-robin winner, latency formula, line assembly).
module tb_mem_port_sched;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int BS = 4;
   localparam int LW = DW * BS;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] addr_mem;
   logic          rd_mem;
   logic          wr_mem;
   logic [DW-1:0] wdata_mem;
   logic [DW-1:0] rdata_mem = '0;
   logic          ready_mem = 1'b1;

   always #5 clock = ~clock;

   mem_req_if #(.AWIDTH(AW), .LW(LW)) m0_if ();
   mem_req_if #(.AWIDTH(AW), .LW(LW)) m1_if ();

   mem_port_sched #(.AWIDTH(AW), .DWIDTH(DW), .BLOCKSIZE(BS)) dut (
      .clock     (clock),
      .reset     (reset),
      .m0        (m0_if),
      .m1        (m1_if),
      .addr_mem  (addr_mem),
      .rd_mem    (rd_mem),
      .wr_mem    (wr_mem),
      .wdata_mem (wdata_mem),
      .rdata_mem (rdata_mem),
      .ready_mem (ready_mem)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Controls written only by the stimulus block.
   int        force_lat = 0;
   bit        hold_low  = 1'b0;
   bit        mem_stuck = 1'b0;
   bit        use_fixed = 1'b0;
   logic [7:0] fixed_beats [BS];

   // State written only by the memory model.
   int        ph = 0, low_cnt = 0, hi_cnt = 0, cur_lat = 0, rb = 0;
   bit        cur_is_rd = 1'b0, extra_nz = 1'b0, excl_bad = 1'b0;
   logic [7:0] beats [BS];
   logic [7:0] wcap  [BS];

   // Behavioural memory: goes busy the cycle it sees a command, takes write
   // beats on busy cycles, returns read beats right after it turns ready.
   always @(negedge clock) begin
      if (reset) begin
         ready_mem = 1'b1;
         ph        = 0;
      end else begin
         if (rd_mem && wr_mem) excl_bad = 1'b1;
         if (ph != 0 && (rd_mem || wr_mem)) hi_cnt++;
         case (ph)
            0: begin
               rdata_mem = 8'($urandom);
               if (hold_low) begin
                  ready_mem = 1'b0;
               end else if ((rd_mem || wr_mem) && !mem_stuck) begin
                  cur_is_rd = rd_mem;
                  if (force_lat > 0)  cur_lat = force_lat;
                  else if (rd_mem)    cur_lat = int'($urandom_range(1, 6));
                  else                cur_lat = int'($urandom_range(BS, BS + 3));
                  for (int i = 0; i < BS; i++)
                     beats[i] = use_fixed ? fixed_beats[i] : 8'($urandom);
                  ready_mem = 1'b0;
                  low_cnt   = 1;
                  hi_cnt    = 1;
                  extra_nz  = 1'b0;
                  if (wr_mem) wcap[0] = wdata_mem;
                  ph = 1;
               end else begin
                  ready_mem = 1'b1;
               end
            end
            1: begin
               if (low_cnt < cur_lat) begin
                  if (!cur_is_rd) begin
                     if (low_cnt < BS)        wcap[low_cnt] = wdata_mem;
                     else if (wdata_mem != 0) extra_nz = 1'b1;
                  end
                  low_cnt++;
               end else begin
                  ready_mem = 1'b1;
                  rb = 0;
                  ph = cur_is_rd ? 2 : 0;
               end
            end
            default: begin
               if (rb < BS) begin
                  rdata_mem = beats[rb];
                  rb++;
               end else begin
                  rdata_mem = 8'($urandom);
                  ph = 0;
               end
            end
         endcase
      end
   end

   // Reference model state
   int         ptr_m = 0;
   logic [LW-1:0] exp_rdata [2];
   logic          t_we    [2];
   logic [AW-1:0] t_addr  [2];
   logic [LW-1:0] t_wd    [2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic randomize_port(input int p);
      t_we[p]   = 1'($urandom_range(0, 1));
      t_addr[p] = 16'($urandom);
      t_wd[p]   = 32'($urandom);
   endtask

   task automatic drive_port(input int p);
      if (p == 0) begin
         m0_if.we = t_we[0]; m0_if.addr = t_addr[0]; m0_if.wdata = t_wd[0]; m0_if.req = 1'b1;
      end else begin
         m1_if.we = t_we[1]; m1_if.addr = t_addr[1]; m1_if.wdata = t_wd[1]; m1_if.req = 1'b1;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, 64'({m0_if.gnt, m1_if.gnt, m0_if.done, m1_if.done,
                                rd_mem, wr_mem, wdata_mem, addr_mem}), 64'd0);
      check({tag, "_rdata"}, {m0_if.rdata, m1_if.rdata}, 64'd0);
   endtask

   // Serve every port in mask; the model predicts winner order and timing.
   task automatic run(input logic [1:0] mask, input int lat);
      logic [1:0] pending;
      int n, k, w, exp_w;
      bit extra_g;
      pending   = mask;
      force_lat = lat;
      for (int p = 0; p < 2; p++) if (mask[p]) drive_port(p);
      while (pending != 2'b00) begin
         n = 0;
         do begin tick(); n++; end while (!(m0_if.gnt || m1_if.gnt) && n < 50);
         if (!(m0_if.gnt || m1_if.gnt)) begin
            check("gnt_timeout", 64'(n), 64'(1));
            m0_if.req = 1'b0; m1_if.req = 1'b0;
            return;
         end
         check("gnt_exclusive", 64'(m0_if.gnt & m1_if.gnt), 64'd0);
         w     = m1_if.gnt ? 1 : 0;
         exp_w = (pending == 2'b11) ? ptr_m : (pending[1] ? 1 : 0);
         check("gnt_winner", 64'(w), 64'(exp_w));
         check("gnt_delay", 64'(n), 64'(1));
         check("addr_mem", 64'(addr_mem), 64'({t_addr[w][AW-1:2], 2'b00}));
         check("cmd_kind", 64'({rd_mem, wr_mem}), t_we[w] ? 64'd1 : 64'd2);
         k = 0;
         extra_g = 1'b0;
         do begin
            tick(); k++;
            if (m0_if.gnt || m1_if.gnt) extra_g = 1'b1;
         end while (!((w == 1) ? m1_if.done : m0_if.done) && k < 300);
         check("done_latency", 64'(k), t_we[w] ? 64'(cur_lat + 2) : 64'(cur_lat + BS + 2));
         check("no_regrant", 64'(extra_g), 64'd0);
         check("other_done_quiet", 64'((w == 1) ? m0_if.done : m1_if.done), 64'd0);
         check("cmd_cycles", 64'(hi_cnt), 64'd1);
         if (t_we[w]) begin
            check("wr_beats", 64'({wcap[3], wcap[2], wcap[1], wcap[0]}), 64'(t_wd[w]));
            check("wr_tail_zero", 64'(extra_nz), 64'd0);
         end else begin
            exp_rdata[w] = {beats[3], beats[2], beats[1], beats[0]};
         end
         check("rdata0", 64'(m0_if.rdata), 64'(exp_rdata[0]));
         check("rdata1", 64'(m1_if.rdata), 64'(exp_rdata[1]));
         if (w == 1) m1_if.req = 1'b0; else m0_if.req = 1'b0;
         pending[w] = 1'b0;
         ptr_m = (w == 0) ? 1 : 0;
      end
      tick();
      check("done_pulse_end", 64'({m0_if.done, m1_if.done}), 64'd0);
      check("rd_wr_excl", 64'(excl_bad), 64'd0);
   endtask

   initial begin
      int n, cnt_rd;
      bit any_done, any_g1;

      reset = 1'b1;
      m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
      m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      fixed_beats[0] = 8'h11; fixed_beats[1] = 8'h22;
      fixed_beats[2] = 8'h33; fixed_beats[3] = 8'h44;
      repeat (3) tick();
      check_zero("reset_state");
      reset = 1'b0;
      tick();

      // Directed single read: m0 reads 0x1234, three busy cycles.
      t_we[0] = 1'b0; t_addr[0] = 16'h1234; t_wd[0] = 32'h0;
      use_fixed = 1'b1;
      run(2'b01, 3);
      use_fixed = 1'b0;
      check("read_line_value", 64'(m0_if.rdata), 64'h44332211);

      // Directed single write: m1 writes 0xDEADBEEF to 0x0040, four busy cycles.
      t_we[1] = 1'b1; t_addr[1] = 16'h0040; t_wd[1] = 32'hDEADBEEF;
      run(2'b10, 4);

      // Simultaneous requests, repeated.
      for (int r = 0; r < 3; r++) begin
         randomize_port(0); randomize_port(1);
         run(2'b11, 0);
      end

      // Memory not ready in IDLE: no grant, no command until it is.
      hold_low = 1'b1;
      tick();
      randomize_port(0);
      t_we[0] = 1'b0;
      drive_port(0);
      repeat (4) begin
         tick();
         check("busy_idle_hold", 64'({m0_if.gnt, m1_if.gnt, rd_mem, wr_mem}), 64'd0);
      end
      hold_low = 1'b0;
      run(2'b01, 0);

      // Reset in the middle of a read burst, after two beats.
      randomize_port(0);
      t_we[0] = 1'b0;
      force_lat = 2;
      drive_port(0);
      n = 0;
      do begin tick(); n++; end while (!m0_if.gnt && n < 20);
      check("mid_reset_gnt", 64'(m0_if.gnt), 64'd1);
      repeat (5) tick();
      reset = 1'b1;
      m0_if.req = 1'b0;
      #1;
      check_zero("async_reset");
      repeat (2) begin
         tick();
         check("reset_no_done", 64'({m0_if.done, m1_if.done}), 64'd0);
      end
      reset = 1'b0;
      force_lat = 0;
      ptr_m = 0;
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      randomize_port(0); randomize_port(1);
      t_we[1] = 1'b0;
      run(2'b11, 0);

      // Randomized mix of lone and simultaneous requests.
      for (int r = 0; r < 12; r++) begin
         randomize_port(0); randomize_port(1);
         run(2'($urandom_range(1, 3)), 0);
      end

      // Memory that never goes busy: command held, no completion, m1 starved.
      mem_stuck = 1'b1;
      randomize_port(0);
      t_we[0] = 1'b0;
      drive_port(0);
      n = 0;
      do begin tick(); n++; end while (!m0_if.gnt && n < 20);
      check("stuck_gnt", 64'(m0_if.gnt), 64'd1);
      randomize_port(1);
      drive_port(1);
      cnt_rd = 0; any_done = 1'b0; any_g1 = 1'b0;
      repeat (30) begin
         tick();
         if (rd_mem) cnt_rd++;
         if (m0_if.done || m1_if.done) any_done = 1'b1;
         if (m1_if.gnt) any_g1 = 1'b1;
      end
      check("stuck_rd_held", 64'(cnt_rd), 64'd30);
      check("stuck_no_done", 64'(any_done), 64'd0);
      check("stuck_m1_unserved", 64'(any_g1), 64'd0);
      reset = 1'b1;
      m0_if.req = 1'b0; m1_if.req = 1'b0;
      tick();
      reset = 1'b0;
      mem_stuck = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
